// File: rtl/sm_board_pkg.sv
// Shared board-side definitions for the schoolMIPS front end: debounce FSM encoding and
// default 50 MHz timing constants.
package sm_board_pkg;

    typedef enum logic {
        SM_DB_IDLE     = 1'b0,
        SM_DB_CHANGING = 1'b1
    } sm_db_state_t;

    localparam int unsigned SM_KEY_NUM            = 4;
    localparam int unsigned SM_DEBOUNCE_CYCLES    = 500000;     // 10 ms @ 50 MHz
    localparam int unsigned SM_STEP_KEY           = 1;
    localparam int unsigned SM_REPEAT_DELAY       = 25000000;   // 500 ms @ 50 MHz
    localparam int unsigned SM_REPEAT_PERIOD      = 5000000;    // 100 ms @ 50 MHz

endpackage

// File: rtl/sm_debounce_cell.sv
// One push-button: 2-flop synchroniser, IDLE/CHANGING debounce FSM with stability counter,
// registered level and press/release pulses. DEBOUNCE_CYCLES must be at least 2.
module sm_debounce_cell
    import sm_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SM_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_press_c,
    output logic key_release_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             key_s;
    sm_db_state_t     state;
    sm_db_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;

    assign key_s = ~sync_q2;

    // Sync flops reset to "released" so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1     <= 1'b1;
            sync_q2     <= 1'b1;
            state       <= SM_DB_IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync_q1     <= key_raw_n;
            sync_q2     <= sync_q1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= key_press_c;
            key_release <= key_release_c;
        end
    end

    // Accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = key_level;
        case (state)
            SM_DB_IDLE: begin
                if (key_s != key_level) begin
                    state_nxt = SM_DB_CHANGING;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            SM_DB_CHANGING: begin
                if (key_s == key_level) begin
                    state_nxt = SM_DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    level_nxt = ~key_level;
                    state_nxt = SM_DB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = SM_DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign key_press_c   = level_nxt & ~key_level;
    assign key_release_c = ~level_nxt & key_level;

endmodule

// File: rtl/sm_step_ctrl.sv
// Board-side key/switch front end and single-step clock enable for sm_top.
// Optional auto-repeat on the step key is enabled by defining SM_STEP_AUTOREPEAT_EN.
module sm_step_ctrl
    import sm_board_pkg::*;
#(
    parameter int unsigned KEY_NUM         = SM_KEY_NUM,
    parameter int unsigned DEBOUNCE_CYCLES = SM_DEBOUNCE_CYCLES,
    parameter int unsigned STEP_KEY        = SM_STEP_KEY,
    parameter int unsigned REPEAT_DELAY    = SM_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = SM_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] keyRaw_n,
    input  logic               swRun,
    output logic [KEY_NUM-1:0] keyLevel,
    output logic [KEY_NUM-1:0] keyPress,
    output logic [KEY_NUM-1:0] keyRelease,
    output logic               stepEn
);

    logic [KEY_NUM-1:0] press_c;
    logic [KEY_NUM-1:0] release_c;
    logic               run_q1;
    logic               run_s;
    logic               rpt_pulse;
    logic               unused_taps;

    for (genvar i = 0; i < int'(KEY_NUM); i++) begin : g_key
        sm_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk           (clk),
            .rst           (rst),
            .key_raw_n     (keyRaw_n[i]),
            .key_level     (keyLevel[i]),
            .key_press     (keyPress[i]),
            .key_release   (keyRelease[i]),
            .key_press_c   (press_c[i]),
            .key_release_c (release_c[i])
        );
    end

    // Only the step key's next-cycle strobes feed the enable path.
    assign unused_taps = ^{press_c, release_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q1 <= 1'b0;
            run_s  <= 1'b0;
        end else begin
            run_q1 <= swRun;
            run_s  <= run_q1;
        end
    end

`ifdef SM_STEP_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_active;

    // Down-counter reloads while idle, so the first repeat lands REPEAT_DELAY cycles after the press.
    assign rpt_active = keyLevel[STEP_KEY] & ~run_s;
    assign rpt_pulse  = rpt_active & ~release_c[STEP_KEY] & (rpt_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || !rpt_active) begin
            rpt_cnt <= RPT_W'(REPEAT_DELAY - 1);
        end else if (rpt_cnt == '0) begin
            rpt_cnt <= RPT_W'(REPEAT_PERIOD - 1);
        end else begin
            rpt_cnt <= rpt_cnt - RPT_W'(1);
        end
    end
`else
    localparam int unsigned UNUSED_RPT = REPEAT_DELAY + REPEAT_PERIOD;

    assign rpt_pulse = 1'b0;
`endif

    // Next-cycle press strobe keeps stepEn aligned with keyPress of the step key.
    always_ff @(posedge clk) begin
        if (rst) begin
            stepEn <= 1'b0;
        end else begin
            stepEn <= run_s | press_c[STEP_KEY] | rpt_pulse;
        end
    end

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Self-checking bench for sm_step_ctrl: directed scenarios plus random key/switch/reset
// activity, compared every cycle against a sample-history reference model.
module tb_sm_step_ctrl;

    localparam int KN = 4;
    localparam int DB = 4;
    localparam int SK = 1;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk;
    logic          rst;
    logic [KN-1:0] keyRaw_n;
    logic          swRun;
    logic [KN-1:0] keyLevel;
    logic [KN-1:0] keyPress;
    logic [KN-1:0] keyRelease;
    logic          stepEn;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [KN-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    bit          m_r1, m_r2, m_step;
    bit          hist [KN][DB];
    int          m_n = 0;
    int          m_start = 0;

    sm_step_ctrl #(
        .KEY_NUM         (KN),
        .DEBOUNCE_CYCLES (DB),
        .STEP_KEY        (SK),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keyRaw_n   (keyRaw_n),
        .swRun      (swRun),
        .keyLevel   (keyLevel),
        .keyPress   (keyPress),
        .keyRelease (keyRelease),
        .stepEn     (stepEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, m_n);
        end
    endtask

    // A level flips once the last DB synchronised samples all disagree with it.
    task automatic model_step();
        bit [KN-1:0] ks;
        bit [KN-1:0] lvl_new;
        bit          all_diff;
        bit          run_pre;
`ifdef SM_STEP_AUTOREPEAT_EN
        int          age;
`endif
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_r1 = 0; m_r2 = 0;
            m_level = '0; m_press = '0; m_rel = '0; m_step = 0;
            foreach (hist[k, j]) hist[k][j] = 0;
            m_start = m_n;
        end else begin
            ks      = ~m_s2;
            run_pre = m_r2;
            lvl_new = m_level;
            for (int k = 0; k < KN; k++) begin
                for (int j = DB - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = ks[k];
                all_diff = 1;
                for (int j = 0; j < DB; j++) if (hist[k][j] == m_level[k]) all_diff = 0;
                if (all_diff) lvl_new[k] = ~m_level[k];
            end
            m_press = lvl_new & ~m_level;
            m_rel   = ~lvl_new & m_level;
            m_step  = run_pre | m_press[SK];
`ifdef SM_STEP_AUTOREPEAT_EN
            if (!(m_level[SK] && !run_pre)) begin
                m_start = m_n;
            end else if (!m_rel[SK]) begin
                age = m_n - m_start;
                if (age >= RD && ((age - RD) % RP) == 0) m_step = 1;
            end
`endif
            m_level = lvl_new;
            m_s2 = m_s1; m_s1 = keyRaw_n;
            m_r2 = m_r1; m_r1 = swRun;
        end
        m_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("keyLevel",   32'(keyLevel),   32'(m_level));
        chk("keyPress",   32'(keyPress),   32'(m_press));
        chk("keyRelease", 32'(keyRelease), 32'(m_rel));
        chk("stepEn",     32'(stepEn),     32'(m_step));
    endtask

    initial begin
        int lat;
        int step_cnt;
        int p2_cnt;
        bit found;

        rst = 1'b1; keyRaw_n = '1; swRun = 1'b0;

        // Reset with all keys released
        repeat (3) tick();
        chk("reset_outputs", 32'({keyLevel, keyPress, keyRelease, stepEn}), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("post_reset_level", 32'(keyLevel), 32'd0);

        // Clean press on key 0: accepted 2 + DB cycles after the edge
        keyRaw_n[0] = 1'b0;
        lat = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (keyPress[0]) begin found = 1; lat = i; end
        end
        chk("press_latency", 32'(lat), 32'd6);
        chk("key0_level", 32'(keyLevel[0]), 32'd1);
        repeat (3) tick();
        keyRaw_n[0] = 1'b1;
        repeat (10) tick();

        // Bouncing key 2 never gets accepted
        p2_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            keyRaw_n[2] = ~keyRaw_n[2];
            repeat (2) begin tick(); p2_cnt += int'(keyPress[2]) + int'(keyRelease[2]); end
        end
        keyRaw_n[2] = 1'b1;
        repeat (10) begin tick(); p2_cnt += int'(keyPress[2]) + int'(keyRelease[2]); end
        chk("bounce_pulses", 32'(p2_cnt), 32'd0);
        chk("bounce_level", 32'(keyLevel[2]), 32'd0);

        // Two step-key presses in step mode give two single-cycle enables
        step_cnt = 0;
        repeat (2) begin
            keyRaw_n[SK] = 1'b0;
            repeat (10) begin tick(); step_cnt += int'(stepEn); end
            keyRaw_n[SK] = 1'b1;
            repeat (10) begin tick(); step_cnt += int'(stepEn); end
        end
        chk("step_pulses", 32'(step_cnt), 32'd2);

        // Run mode while the key is held, then back to step mode
        keyRaw_n[SK] = 1'b0;
        repeat (10) tick();
        swRun = 1'b1;
        repeat (6) tick();
        chk("run_enable", 32'(stepEn), 32'd1);
        swRun = 1'b0;
        repeat (4) tick();
        chk("run_stop", 32'(stepEn), 32'd0);
        keyRaw_n[SK] = 1'b1;
        repeat (12) tick();

        // Step key held for 20 cycles after the press
        keyRaw_n[SK] = 1'b0;
        found = 0; step_cnt = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (keyPress[SK]) begin found = 1; step_cnt = int'(stepEn); end
        end
        chk("hold_press_seen", 32'(found), 32'd1);
        repeat (19) begin tick(); step_cnt += int'(stepEn); end
`ifdef SM_STEP_AUTOREPEAT_EN
        chk("hold_step_pulses", 32'(step_cnt), 32'd5);
`else
        chk("hold_step_pulses", 32'(step_cnt), 32'd1);
`endif
        keyRaw_n[SK] = 1'b1;
        repeat (12) tick();

        // Reset while key 3 is mid-debounce
        keyRaw_n[3] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("reset_mid_change", 32'({keyLevel, keyPress, keyRelease, stepEn}), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        keyRaw_n[3] = 1'b1;
        repeat (10) tick();

        // Random keys, run switch and occasional reset
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < KN; k++)
                if ($urandom_range(7) == 0) keyRaw_n[k] = ~keyRaw_n[k];
            if ($urandom_range(63) == 0) swRun = ~swRun;
            rst = ($urandom_range(299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
